v_red_unit: RTL and testbench

V_RED_UNIT -- requirements
Module: v_red_unit

---
 rtl/v_pkg.sv | 54 +++++
 rtl/v_red_op.sv | 46 ++++
 rtl/v_red_unit.sv | 145 ++++++++++++++
 tb/tb_v_red_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_pkg.sv
// Shared types for the vector reduction unit: reduction opcodes, element
// widths, FSM state encoding and small SEW helper functions.
package v_pkg;

  typedef enum logic [5:0] {
    VREDSUM  = 6'b000000,
    VREDAND  = 6'b000001,
    VREDOR   = 6'b000010,
    VREDXOR  = 6'b000011,
    VREDMINU = 6'b000100,
    VREDMIN  = 6'b000101,
    VREDMAXU = 6'b000110,
    VREDMAX  = 6'b000111
  } funct6_red_e;

  typedef enum logic [1:0] {
    VSEW_8       = 2'b00,
    VSEW_16      = 2'b01,
    VSEW_32      = 2'b10,
    VSEW_INVALID = 2'b11
  } vsew_e;

  typedef enum logic [1:0] {
    RED_IDLE  = 2'b00,
    RED_ACCUM = 2'b01,
    RED_DONE  = 2'b10
  } v_red_state_e;

  function automatic logic [31:0] sew_mask(input logic [1:0] vsew);
    case (vsew)
      VSEW_8:  return 32'h0000_00FF;
      VSEW_16: return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Sign-extend the low SEW bits to 32 bits for signed min/max.
  function automatic logic [31:0] sew_sext(input logic [31:0] v, input logic [1:0] vsew);
    case (vsew)
      VSEW_8:  return {{24{v[7]}}, v[7:0]};
      VSEW_16: return {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  function automatic logic funct6_legal(input logic [5:0] f);
    return (f[5:3] == 3'b000);
  endfunction

  function automatic logic cmd_legal(input logic [5:0] f, input logic [1:0] vsew);
    return funct6_legal(f) && (vsew != VSEW_INVALID);
  endfunction

endpackage

// File: rtl/v_red_op.sv
// One SEW-aware two-operand reduction step: y = op(a, b), result truncated
// to SEW and zero-extended to 32 bits.
module v_red_op
  import v_pkg::*;
(
  input  logic [5:0]  funct6_i,
  input  logic [1:0]  vsew_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  logic [31:0] mask;
  logic [31:0] a_t;
  logic [31:0] b_t;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic [31:0] sum;
  logic        b_lt_a_u;
  logic        b_lt_a_s;

  always_comb begin
    mask     = sew_mask(vsew_i);
    a_t      = a_i & mask;
    b_t      = b_i & mask;
    a_s      = sew_sext(a_t, vsew_i);
    b_s      = sew_sext(b_t, vsew_i);
    sum      = (a_t + b_t) & mask;
    b_lt_a_u = (b_t < a_t);
    b_lt_a_s = ($signed(b_s) < $signed(a_s));

    y_o = a_t;
    case (funct6_i)
      VREDSUM:  y_o = sum;
      VREDAND:  y_o = a_t & b_t;
      VREDOR:   y_o = a_t | b_t;
      VREDXOR:  y_o = a_t ^ b_t;
      VREDMINU: y_o = b_lt_a_u ? b_t : a_t;
      VREDMIN:  y_o = b_lt_a_s ? b_t : a_t;
      VREDMAXU: y_o = b_lt_a_u ? a_t : b_t;
      VREDMAX:  y_o = b_lt_a_s ? a_t : b_t;
      default:  y_o = a_t;
    endcase
  end

endmodule

// File: rtl/v_red_unit.sv
// Vector reduction unit: accepts a command, folds LANES elements per beat
// into a SEW-wide accumulator, then presents the result until taken.
//
// state     | meaning
// ----------+-----------------------------------------------------
// RED_IDLE  | waiting for a command; ready_o high
// RED_ACCUM | consuming element beats; data_ready_o high
// RED_DONE  | result held on result_o; result_valid_o high
module v_red_unit
  import v_pkg::*;
#(
  parameter int LANES = 4,
  parameter int VLMAX = 32,
  localparam int VL_W = $clog2(VLMAX) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  ready_o,
  input  logic [5:0]            funct6_i,
  input  logic [1:0]            vsew_i,
  input  logic [VL_W-1:0]       vl_i,
  input  logic                  vm_i,
  input  logic [31:0]           scalar_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  input  logic [32*LANES-1:0]   data_i,
  input  logic [LANES-1:0]      mask_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [31:0]           result_o,
  output logic                  illegal_o
);

  // Headroom so cnt + LANES never wraps for any vl_i value.
  localparam int CNT_W = VL_W + 4;

  v_red_state_e     state_q, state_d;
  logic [5:0]       funct6_q, funct6_d;
  logic [1:0]       vsew_q, vsew_d;
  logic [VL_W-1:0]  vl_q, vl_d;
  logic             vm_q, vm_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;

  logic [CNT_W-1:0]        cnt_next;
  logic [LANES:0][31:0]    lane_acc;
  logic [LANES-1:0]        lane_active;

  // Each lane either folds its element into the running value or passes it on.
  assign lane_acc[0] = acc_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [CNT_W-1:0] elem_idx;
    logic [31:0]      op_y;

    assign elem_idx       = cnt_q + CNT_W'(k);
    assign lane_active[k] = (elem_idx < CNT_W'(vl_q)) && (vm_q || mask_i[k]);

    v_red_op u_op (
      .funct6_i (funct6_q),
      .vsew_i   (vsew_q),
      .a_i      (lane_acc[k]),
      .b_i      (data_i[32*k +: 32]),
      .y_o      (op_y)
    );

    assign lane_acc[k+1] = lane_active[k] ? op_y : lane_acc[k];
  end

  always_comb begin
    state_d   = state_q;
    funct6_d  = funct6_q;
    vsew_d    = vsew_q;
    vl_d      = vl_q;
    vm_d      = vm_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    cnt_next  = cnt_q + CNT_W'(LANES);

    case (state_q)
      RED_IDLE: begin
        if (start_i) begin
          if (!cmd_legal(funct6_i, vsew_i)) begin
            illegal_d = 1'b1;
          end else begin
            funct6_d = funct6_i;
            vsew_d   = vsew_i;
            vl_d     = vl_i;
            vm_d     = vm_i;
            acc_d    = scalar_i & sew_mask(vsew_i);
            cnt_d    = '0;
            state_d  = (vl_i == '0) ? RED_DONE : RED_ACCUM;
          end
        end
      end
      RED_ACCUM: begin
        if (data_valid_i) begin
          acc_d = lane_acc[LANES];
          cnt_d = cnt_next;
          if (cnt_next >= CNT_W'(vl_q)) begin
            state_d = RED_DONE;
          end
        end
      end
      RED_DONE: begin
        if (result_ready_i) begin
          state_d = RED_IDLE;
        end
      end
      default: state_d = RED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RED_IDLE;
      funct6_q  <= '0;
      vsew_q    <= '0;
      vl_q      <= '0;
      vm_q      <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      funct6_q  <= funct6_d;
      vsew_q    <= vsew_d;
      vl_q      <= vl_d;
      vm_q      <= vm_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign ready_o        = (state_q == RED_IDLE);
  assign data_ready_o   = (state_q == RED_ACCUM);
  assign result_valid_o = (state_q == RED_DONE);
  assign result_o       = (state_q == RED_DONE) ? acc_q : 32'h0;
  assign illegal_o      = illegal_q;

endmodule

// File: tb/tb_v_red_unit.sv
// Self-checking bench for v_red_unit: directed scenarios plus randomized
// commands compared against an element-by-element reference model.
module tb_v_red_unit;
  import v_pkg::*;

  localparam int LANES = 4;
  localparam int VLMAX = 32;
  localparam int VL_W  = $clog2(VLMAX) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start_i;
  logic                 ready_o;
  logic [5:0]           funct6_i;
  logic [1:0]           vsew_i;
  logic [VL_W-1:0]      vl_i;
  logic                 vm_i;
  logic [31:0]          scalar_i;
  logic                 data_valid_i;
  logic                 data_ready_o;
  logic [32*LANES-1:0]  data_i;
  logic [LANES-1:0]     mask_i;
  logic                 result_valid_o;
  logic                 result_ready_i;
  logic [31:0]          result_o;
  logic                 illegal_o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] elem [64];
  bit          msk  [64];

  always #5 clk = ~clk;

  v_red_unit #(.LANES(LANES), .VLMAX(VLMAX)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .ready_o        (ready_o),
    .funct6_i       (funct6_i),
    .vsew_i         (vsew_i),
    .vl_i           (vl_i),
    .vm_i           (vm_i),
    .scalar_i       (scalar_i),
    .data_valid_i   (data_valid_i),
    .data_ready_o   (data_ready_o),
    .data_i         (data_i),
    .mask_i         (mask_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_o       (result_o),
    .illegal_o      (illegal_o)
  );

  // Reference: walk elements 0..vl-1 in order, skipping masked ones.
  function automatic logic [31:0] model(input int f6, input int sew, input int vl,
                                        input bit vm, input logic [31:0] scalar);
    longint w, m, half, acc, e, sa, se;
    w    = 64'(8) << sew;
    m    = (longint'(1) << w) - 1;
    half = (m + 1) / 2;
    acc  = longint'(scalar) & m;
    for (int i = 0; i < vl; i++) begin
      if (!(vm || msk[i])) continue;
      e  = longint'(elem[i]) & m;
      sa = (acc >= half) ? acc - (m + 1) : acc;
      se = (e >= half) ? e - (m + 1) : e;
      case (f6)
        0: acc = (acc + e) & m;
        1: acc = acc & e;
        2: acc = acc | e;
        3: acc = acc ^ e;
        4: acc = (e < acc) ? e : acc;
        5: acc = (se < sa) ? e : acc;
        6: acc = (e > acc) ? e : acc;
        7: acc = (se > sa) ? e : acc;
        default: acc = acc;
      endcase
    end
    return acc[31:0];
  endfunction

  task automatic idle_inputs();
    start_i        = 1'b0;
    funct6_i       = '0;
    vsew_i         = '0;
    vl_i           = '0;
    vm_i           = 1'b1;
    scalar_i       = '0;
    data_valid_i   = 1'b0;
    data_i         = '0;
    mask_i         = '0;
    result_ready_i = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      elem[i] = $urandom;
      msk[i]  = 1'($urandom_range(0, 1));
    end
  endtask

  // Issues one command, streams beats from elem/msk, then takes the result.
  task automatic run_cmd(input logic [5:0] f6, input logic [1:0] sew, input int vl,
                         input bit vm, input logic [31:0] scalar, input bit gaps,
                         output logic [31:0] res, output int beats);
    int  exp_beats;
    int  cyc;
    int  hold;
    int  idx;
    bit  done;
    exp_beats = (vl + LANES - 1) / LANES;
    beats = 0;
    tests_run++;
    if (ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL cmd_ready: ready_o=%b required 1", ready_o);
    end
    funct6_i = f6; vsew_i = sew; vl_i = VL_W'(vl); vm_i = vm; scalar_i = scalar;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    done = (vl == 0);
    cyc = 0;
    while (!done && cyc < 500) begin
      data_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int k = 0; k < LANES; k++) begin
        idx = (beats * LANES + k) % 64;
        data_i[32*k +: 32] = elem[idx];
        mask_i[k]          = msk[idx];
      end
      if (data_valid_i && data_ready_o) begin
        beats++;
        if (beats == exp_beats) done = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    data_valid_i = 1'b0;
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL beat_timeout: beats=%0d required %0d", beats, exp_beats);
    end
    tests_run++;
    if (result_valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL result_latency: result_valid_o=%b required 1 one cycle after last beat", result_valid_o);
    end
    tests_run++;
    if (data_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL extra_beat: data_ready_o=%b required 0 after final beat", data_ready_o);
    end
    res = result_o;
    hold = $urandom_range(0, 2);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      tests_run++;
      if (result_o !== res || result_valid_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL result_stable: result_o=%h valid=%b required %h valid 1", result_o, result_valid_o, res);
      end
    end
    result_ready_i = 1'b1;
    @(posedge clk); #1;
    result_ready_i = 1'b0;
    tests_run++;
    if (result_valid_o !== 1'b0 || ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL result_release: valid=%b ready=%b required 0/1", result_valid_o, ready_o);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (ready_o !== 1'b1 || data_ready_o !== 1'b0 || result_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hs: ready=%b data_ready=%b result_valid=%b required 1/0/0", ready_o, data_ready_o, result_valid_o);
    end
    tests_run++;
    if (result_o !== 32'h0 || illegal_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out: result_o=%h illegal=%b required 0/0", result_o, illegal_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sum32();
    logic [31:0] res; int beats;
    for (int i = 0; i < 8; i++) elem[i] = 32'(i + 1);
    run_cmd(VREDSUM, VSEW_32, 5, 1'b1, 32'd10, 1'b0, res, beats);
    tests_run++;
    if (res !== 32'd25) begin
      tests_failed++;
      $display("FAIL sum32: result=%0d required 25", res);
    end
    tests_run++;
    if (beats !== 2) begin
      tests_failed++;
      $display("FAIL sum32_beats: beats=%0d required 2", beats);
    end
  endtask

  task automatic test_max8();
    logic [31:0] res; int beats;
    elem[0] = 32'hABCD_EF7F; elem[1] = 32'h1234_5680; elem[2] = 32'h0000_0005; elem[3] = 32'hFFFF_FFFF;
    run_cmd(VREDMAX, VSEW_8, 3, 1'b1, 32'h0, 1'b0, res, beats);
    tests_run++;
    if (res !== 32'h7F) begin
      tests_failed++;
      $display("FAIL max8: result=%h required 0000007f", res);
    end
    run_cmd(VREDMAXU, VSEW_8, 3, 1'b1, 32'h0, 1'b0, res, beats);
    tests_run++;
    if (res !== 32'h80) begin
      tests_failed++;
      $display("FAIL maxu8: result=%h required 00000080", res);
    end
  endtask

  task automatic test_wrap16();
    logic [31:0] res; int beats;
    elem[0] = 32'h5555_0002;
    run_cmd(VREDSUM, VSEW_16, 1, 1'b1, 32'hABCD_FFFF, 1'b0, res, beats);
    tests_run++;
    if (res !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL wrap16: result=%h required 00000001", res);
    end
  endtask

  task automatic test_vl0();
    logic [31:0] res; int beats;
    run_cmd(VREDSUM, VSEW_32, 0, 1'b1, 32'h1234, 1'b0, res, beats);
    tests_run++;
    if (res !== 32'h1234 || beats !== 0) begin
      tests_failed++;
      $display("FAIL vl0: result=%h beats=%0d required 00001234/0", res, beats);
    end
  endtask

  task automatic test_mask_or();
    logic [31:0] res; int beats;
    elem[0] = 1; elem[1] = 2; elem[2] = 4; elem[3] = 8;
    msk[0] = 1; msk[1] = 0; msk[2] = 1; msk[3] = 0;
    run_cmd(VREDOR, VSEW_32, 4, 1'b0, 32'h0, 1'b0, res, beats);
    tests_run++;
    if (res !== 32'h5) begin
      tests_failed++;
      $display("FAIL mask_or: result=%h required 00000005", res);
    end
    for (int i = 0; i < 8; i++) msk[i] = 0;
    run_cmd(VREDSUM, VSEW_8, 6, 1'b0, 32'hDEAD_BEEF, 1'b0, res, beats);
    tests_run++;
    if (res !== 32'hEF) begin
      tests_failed++;
      $display("FAIL all_masked: result=%h required 000000ef", res);
    end
  endtask

  task automatic test_illegal_rst();
    funct6_i = VREDSUM; vsew_i = 2'b11; vl_i = VL_W'(4); vm_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    tests_run++;
    if (illegal_o !== 1'b1 || ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_sew: illegal=%b ready=%b required 1/1", illegal_o, ready_o);
    end
    @(posedge clk); #1;
    tests_run++;
    if (illegal_o !== 1'b0 || ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_pulse: illegal=%b ready=%b required 0/1", illegal_o, ready_o);
    end
    funct6_i = 6'b001000; vsew_i = VSEW_8; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    tests_run++;
    if (illegal_o !== 1'b1 || ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_f6: illegal=%b ready=%b required 1/1", illegal_o, ready_o);
    end
    @(posedge clk); #1;
    funct6_i = VREDSUM; vsew_i = VSEW_32; vl_i = VL_W'(12); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    data_valid_i = 1'b1;
    @(posedge clk); #1;
    data_valid_i = 1'b0;
    vsew_i = 2'b11; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    tests_run++;
    if (illegal_o !== 1'b0 || data_ready_o !== 1'b1 || ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_in_accum: illegal=%b data_ready=%b ready=%b required 0/1/0", illegal_o, data_ready_o, ready_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (ready_o !== 1'b1 || data_ready_o !== 1'b0 || result_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_rst: ready=%b data_ready=%b result_valid=%b required 1/0/0", ready_o, data_ready_o, result_valid_o);
    end
    rst = 1'b0;
    data_valid_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      tests_run++;
      if (result_valid_o !== 1'b0 || ready_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL post_rst: valid=%b ready=%b required 0/1", result_valid_o, ready_o);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] res, exp, scalar;
    int beats, f6, sew, vl;
    bit vm;
    for (int n = 0; n < 40; n++) begin
      fill_random();
      f6     = $urandom_range(0, 7);
      sew    = $urandom_range(0, 2);
      vl     = $urandom_range(0, 20);
      vm     = 1'($urandom_range(0, 1));
      scalar = $urandom;
      exp    = model(f6, sew, vl, vm, scalar);
      run_cmd(6'(f6), 2'(sew), vl, vm, scalar, 1'b1, res, beats);
      tests_run++;
      if (res !== exp || beats !== (vl + LANES - 1) / LANES) begin
        tests_failed++;
        $display("FAIL random_%0d: f6=%0d sew=%0d vl=%0d vm=%0d result=%h beats=%0d required %h beats %0d",
                 n, f6, sew, vl, vm, res, beats, exp, (vl + LANES - 1) / LANES);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      elem[i] = '0;
      msk[i]  = 1'b1;
    end
    test_reset();
    test_sum32();
    test_max8();
    test_wrap16();
    test_vl0();
    test_mask_or();
    test_illegal_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
